mem_arbiter: RTL and testbench

- Shares the single external 64-bit memory port between the instruction-fetch requester and the load/store (data) requester.
- Runs one transaction at a time. Data has priority, with a starvation guard so fetch always makes progress.
- Holds a request on the memory bus until `mem_ack`, returns the response to the winning requester, and aborts hung transactions after a programmable timeout.
- Sits between the fetch/LSU stages and the top-level memory interface.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_pick.sv | 63 ++++++
 rtl/mem_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mem_arb_pkg                                                 |
// | Brief   : Shared types for the fetch/data memory arbiter              |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Owner of the transaction currently on the memory port
   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mem_arb_pick                                                |
// | Brief   : Data-first priority pick with a saturating starvation       |
// |           counter that forces a fetch grant after STARVE_MAX data     |
// |           grants made while fetch was waiting                         |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   i_req,
   input  logic   d_req,
   input  logic   idle,
   input  logic   grant,
   input  owner_e owner,
   output logic   grant_i,
   output logic   grant_d
);

   localparam int            CW    = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] C_MAX = CW'(STARVE_MAX);

   logic [CW-1:0] starve_q;
   logic [CW-1:0] starve_d;
   logic          w_force_fetch;

   // Priority pick: data wins ties unless fetch has been starved long enough
   always_comb begin
      w_force_fetch = (starve_q == C_MAX);
      grant_i       = i_req & (~d_req | w_force_fetch);
      grant_d       = d_req & ~grant_i;
   end

   // Starvation counter next value: counts data grants while fetch waits
   always_comb begin
      starve_d = starve_q;
      if (grant && (owner == OWN_I)) begin
         starve_d = '0;
      end else if (grant && (owner == OWN_D) && i_req) begin
         if (starve_q != C_MAX) begin
            starve_d = starve_q + CW'(1);
         end
      end else if (idle && !i_req) begin
         starve_d = '0;
      end
   end

   // Starvation counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mem_arbiter                                                 |
// | Brief   : Shares one 64-bit memory port between instruction fetch and |
// |           load/store. One transaction at a time, data priority with   |
// |           starvation guard, programmable timeout abort.               |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 256
) (
   input  logic                clk,
   input  logic                rst,
   // fetch requester
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_valid,
   output logic                i_err,
   // data requester
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_valid,
   output logic                d_err,
   // memory port
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int            BW       = DATA_W / 8;
   localparam int            TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam bit            C_TMO_EN = (TIMEOUT != 0);
   localparam logic [TW-1:0] C_TMO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_e              state_q,     state_d;
   owner_e              owner_q,     owner_d;
   logic [TW-1:0]       tmo_q,       tmo_d;
   logic                mem_req_q,   mem_req_d;
   logic                mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [BW-1:0]       mem_be_q,    mem_be_d;
   logic [DATA_W-1:0]   i_rdata_q,   i_rdata_d;
   logic                i_valid_q,   i_valid_d;
   logic                i_err_q,     i_err_d;
   logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
   logic                d_valid_q,   d_valid_d;
   logic                d_err_q,     d_err_d;

   logic                w_grant_i;
   logic                w_grant_d;
   logic                w_idle;
   logic                w_grant;
   owner_e              w_pick_owner;
   logic                w_tmo_hit;

   // Grant strobe and winner fed back so the starvation counter can track it
   always_comb begin
      w_idle       = (state_q == ST_IDLE);
      w_grant      = w_idle & (w_grant_i | w_grant_d);
      w_pick_owner = w_grant_d ? OWN_D : OWN_I;
      w_tmo_hit    = C_TMO_EN && (tmo_q == C_TMO_LAST);
   end

   mem_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .clk     (clk),
      .rst     (rst),
      .i_req   (i_req),
      .d_req   (d_req),
      .idle    (w_idle),
      .grant   (w_grant),
      .owner   (w_pick_owner),
      .grant_i (w_grant_i),
      .grant_d (w_grant_d)
   );

   // FSM next state plus datapath and response register next values
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      tmo_d       = '0;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_valid_d   = 1'b0;
      i_err_d     = 1'b0;
      d_valid_d   = 1'b0;
      d_err_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_grant_d) begin
               state_d     = ST_BUSY;
               owner_d     = OWN_D;
               mem_req_d   = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_be_d    = d_be;
            end else if (w_grant_i) begin
               state_d     = ST_BUSY;
               owner_d     = OWN_I;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = i_addr;
               mem_wdata_d = '0;
               mem_be_d    = '1;
            end
         end

         ST_BUSY: begin
            tmo_d = tmo_q + TW'(1);
            // An ack in the timeout cycle is still a normal completion
            if (mem_ack) begin
               state_d   = ST_RESP;
               mem_req_d = 1'b0;
               if (owner_q == OWN_D) begin
                  d_valid_d = 1'b1;
                  d_rdata_d = mem_we_q ? '0 : mem_rdata;
               end else begin
                  i_valid_d = 1'b1;
                  i_rdata_d = mem_rdata;
               end
            end else if (w_tmo_hit) begin
               state_d   = ST_RESP;
               mem_req_d = 1'b0;
               if (owner_q == OWN_D) begin
                  d_valid_d = 1'b1;
                  d_err_d   = 1'b1;
                  d_rdata_d = '0;
               end else begin
                  i_valid_d = 1'b1;
                  i_err_d   = 1'b1;
                  i_rdata_d = '0;
               end
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_I;
         tmo_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         i_rdata_q   <= '0;
         i_valid_q   <= 1'b0;
         i_err_q     <= 1'b0;
         d_rdata_q   <= '0;
         d_valid_q   <= 1'b0;
         d_err_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         tmo_q       <= tmo_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         i_rdata_q   <= i_rdata_d;
         i_valid_q   <= i_valid_d;
         i_err_q     <= i_err_d;
         d_rdata_q   <= d_rdata_d;
         d_valid_q   <= d_valid_d;
         d_err_q     <= d_err_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign i_rdata   = i_rdata_q;
   assign i_valid   = i_valid_q;
   assign i_err     = i_err_q;
   assign d_rdata   = d_rdata_q;
   assign d_valid   = d_valid_q;
   assign d_err     = d_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_mem_arbiter                                              |
// | Brief   : Directed self-checking bench for mem_arbiter                |
// |           (STARVE_MAX=2, TIMEOUT=8)                                   |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [63:0] i_addr;
   logic [63:0] i_rdata;
   logic        i_valid;
   logic        i_err;
   logic        d_req;
   logic        d_we;
   logic [63:0] d_addr;
   logic [63:0] d_wdata;
   logic [7:0]  d_be;
   logic [63:0] d_rdata;
   logic        d_valid;
   logic        d_err;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_be;
   logic        mem_ack;
   logic [63:0] mem_rdata;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(
      .ADDR_W     (64),
      .DATA_W     (64),
      .STARVE_MAX (2),
      .TIMEOUT    (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_rdata   (i_rdata),
      .i_valid   (i_valid),
      .i_err     (i_err),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_be      (d_be),
      .d_rdata   (d_rdata),
      .d_valid   (d_valid),
      .d_err     (d_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // advance one clock; outputs are sampled and inputs driven 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [63:0] exp_order [6];
   int          n;

   initial begin
      rst       = 1'b1;
      i_req     = 1'b0;
      i_addr    = '0;
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = '0;
      d_wdata   = '0;
      d_be      = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      tick();
      tick();

      // ---------------- reset state
      check("rst_mem_req",  64'(mem_req),  64'd0);
      check("rst_i_valid",  64'(i_valid),  64'd0);
      check("rst_d_valid",  64'(d_valid),  64'd0);
      check("rst_mem_addr", mem_addr,      64'd0);
      check("rst_mem_be",   64'(mem_be),   64'd0);
      check("rst_d_rdata",  d_rdata,       64'd0);
      rst = 1'b0;
      tick();

      // ---------------- fetch read
      i_req  = 1'b1;
      i_addr = 64'h100;
      tick();
      check("f_mem_req",   64'(mem_req),  64'd1);
      check("f_mem_addr",  mem_addr,      64'h100);
      check("f_mem_we",    64'(mem_we),   64'd0);
      check("f_mem_be",    64'(mem_be),   64'hFF);
      check("f_mem_wdata", mem_wdata,     64'd0);
      tick();
      check("f_hold_req",  64'(mem_req),  64'd1);
      tick();
      mem_ack   = 1'b1;
      mem_rdata = 64'hDEADBEEF_00000001;
      tick();
      mem_ack = 1'b0;
      i_req   = 1'b0;
      check("f_i_valid",   64'(i_valid),  64'd1);
      check("f_i_rdata",   i_rdata,       64'hDEADBEEF_00000001);
      check("f_i_err",     64'(i_err),    64'd0);
      check("f_d_valid",   64'(d_valid),  64'd0);
      check("f_req_drop",  64'(mem_req),  64'd0);
      tick();
      check("f_valid_1cy", 64'(i_valid),  64'd0);
      check("f_rdata_hold", i_rdata,      64'hDEADBEEF_00000001);

      // ---------------- simultaneous requests: data first, then fetch
      i_req   = 1'b1;
      i_addr  = 64'h300;
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 64'h2000;
      d_be    = 8'h0F;
      d_wdata = 64'h1234;
      tick();
      check("s_mem_addr",  mem_addr,      64'h2000);
      check("s_mem_we",    64'(mem_we),   64'd1);
      check("s_mem_be",    64'(mem_be),   64'h0F);
      check("s_mem_wdata", mem_wdata,     64'h1234);
      mem_ack   = 1'b1;
      mem_rdata = 64'hAAAA_AAAA;
      tick();
      mem_ack = 1'b0;
      d_req   = 1'b0;
      check("s_d_valid",   64'(d_valid),  64'd1);
      check("s_d_rdata",   d_rdata,       64'd0);
      check("s_i_valid",   64'(i_valid),  64'd0);
      tick();
      tick();
      check("s_f_addr",    mem_addr,      64'h300);
      check("s_f_we",      64'(mem_we),   64'd0);
      mem_ack   = 1'b1;
      mem_rdata = 64'h55;
      tick();
      mem_ack = 1'b0;
      i_req   = 1'b0;
      check("s_f_valid",   64'(i_valid),  64'd1);
      check("s_f_rdata",   i_rdata,       64'h55);
      tick();

      // ---------------- starvation: order D, D, I, D, D, I
      exp_order[0] = 64'h500;
      exp_order[1] = 64'h500;
      exp_order[2] = 64'h400;
      exp_order[3] = 64'h500;
      exp_order[4] = 64'h500;
      exp_order[5] = 64'h400;
      i_req  = 1'b1;
      i_addr = 64'h400;
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 64'h500;
      d_be   = 8'hFF;
      for (int k = 0; k < 6; k++) begin
         tick();
         check($sformatf("starve_grant%0d", k), mem_addr, exp_order[k]);
         mem_ack   = 1'b1;
         mem_rdata = 64'h77;
         tick();
         mem_ack = 1'b0;
         tick();
      end
      i_req = 1'b0;
      d_req = 1'b0;
      check("starve_d_rdata", d_rdata, 64'h77);
      tick();

      // ---------------- timeout on a data read with no ack
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 64'h600;
      tick();
      n = 0;
      while (mem_req && n < 20) begin
         n++;
         tick();
      end
      check("to_req_cycles", 64'(n),       64'd8);
      check("to_d_valid",    64'(d_valid), 64'd1);
      check("to_d_err",      64'(d_err),   64'd1);
      check("to_d_rdata",    d_rdata,      64'd0);
      d_req = 1'b0;
      tick();
      check("to_err_clear",  64'(d_err),   64'd0);
      mem_ack   = 1'b1;
      mem_rdata = 64'h99;
      tick();
      mem_ack = 1'b0;
      check("late_d_valid",  64'(d_valid), 64'd0);
      check("late_i_valid",  64'(i_valid), 64'd0);
      check("late_mem_req",  64'(mem_req), 64'd0);
      tick();
      check("late_d_rdata",  d_rdata,      64'd0);

      // ---------------- reset while BUSY
      i_req  = 1'b1;
      i_addr = 64'h700;
      tick();
      check("r_busy_req",    64'(mem_req), 64'd1);
      rst     = 1'b1;
      mem_ack = 1'b1;
      tick();
      rst     = 1'b0;
      mem_ack = 1'b0;
      i_req   = 1'b0;
      check("r_mem_req",     64'(mem_req), 64'd0);
      check("r_i_valid",     64'(i_valid), 64'd0);
      tick();
      check("r_no_valid",    64'(i_valid), 64'd0);
      i_req  = 1'b1;
      i_addr = 64'h800;
      tick();
      check("r_new_addr",    mem_addr,     64'h800);
      mem_ack   = 1'b1;
      mem_rdata = 64'h88;
      tick();
      mem_ack = 1'b0;
      i_req   = 1'b0;
      check("r_new_valid",   64'(i_valid), 64'd1);
      check("r_new_rdata",   i_rdata,      64'h88);
      tick();

      // ---------------- ack in the same cycle as the timeout
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 64'h900;
      tick();
      for (int k = 0; k < 7; k++) begin
         tick();
      end
      check("at_still_req",  64'(mem_req), 64'd1);
      mem_ack   = 1'b1;
      mem_rdata = 64'hC0FFEE;
      tick();
      mem_ack = 1'b0;
      d_req   = 1'b0;
      check("at_d_valid",    64'(d_valid), 64'd1);
      check("at_d_err",      64'(d_err),   64'd0);
      check("at_d_rdata",    d_rdata,      64'hC0FFEE);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
